// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, sequences req/ack instruction fetch and applies EX redirects.
module pc_fetch_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                PC_STEP  = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_req,
  input  logic              branch_taken,
  input  logic              jump_req,
  input  logic [DATA_W-1:0] target_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_pc,
  output logic              flush,
  output logic              misalign
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic              out_q, out_d;
  logic              redir, aligned, act, ack;
  assign redir       = jump_req | (branch_req & branch_taken);
  assign aligned     = (target_pc & DATA_W'(PC_STEP - 1)) == '0;
  assign act         = redir & (state_q != IDLE);
  assign flush       = act & aligned;
  assign misalign    = act & ~aligned;
  assign imem_req    = (state_q == DRAIN) | ((state_q == FETCH) & (~stall | out_q));
  assign imem_addr   = pc_q;
  assign ack         = imem_ack & imem_req;
  assign instr_valid = (state_q == FETCH) & ack & ~flush;
  assign instr_pc    = pc_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // a redirect with no outstanding request abandons nothing; otherwise drain it
        out_d = imem_req & ~ack & ~(flush & ~out_q);
        if (ack) pc_d = flush ? target_pc : pc_q + DATA_W'(PC_STEP);
        else if (flush & out_q) begin
          tgt_d   = target_pc;
          state_d = DRAIN;
        end else if (flush) pc_d = target_pc;
      end
      DRAIN: begin
        if (ack) begin
          pc_d    = flush ? target_pc : tgt_q;
          out_d   = 1'b0;
          state_d = FETCH;
        end else if (flush) tgt_d = target_pc;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vectors; expected fetched PCs go through a scoreboard queue.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, branch_req = 1'b0, branch_taken = 1'b0, jump_req = 1'b0;
  logic [15:0] target_pc = '0;
  logic        imem_req, imem_ack = 1'b0, instr_valid, flush, misalign;
  logic [15:0] imem_addr, instr_pc;
  int          checks = 0, failures = 0;
  logic [15:0] exp_q[$];

  pc_fetch_ctrl #(.DATA_W(16), .PC_STEP(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_req(branch_req), .branch_taken(branch_taken),
    .jump_req(jump_req), .target_pc(target_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_valid(instr_valid), .instr_pc(instr_pc), .flush(flush),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic t, input logic j,
                       input logic [15:0] tg, input logic a);
    stall = s; branch_req = b; branch_taken = t; jump_req = j; target_pc = tg; imem_ack = a;
    @(negedge clk);
  endtask

  task automatic see(input string name, input logic req, input logic [15:0] addr,
                     input logic fl, input logic mis);
    chk({name, "_req"}, {15'd0, imem_req}, {15'd0, req});
    if (req) chk({name, "_addr"}, imem_addr, addr);
    chk({name, "_flush"}, {15'd0, flush}, {15'd0, fl});
    chk({name, "_misalign"}, {15'd0, misalign}, {15'd0, mis});
  endtask

  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: instr_pc %h with empty scoreboard at %0t", instr_pc, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (instr_pc !== e) begin
          failures++;
          $display("FAIL instr_pc: got %h expected %h at %0t", instr_pc, e, $time);
        end
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 16'h0, 0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    see("rst", 0, 0, 0, 0);
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 1, 16'h0040, 1);
    see("idle", 0, 0, 0, 0);
    // T1: ack every cycle
    for (int i = 0; i < 4; i++) begin
      tick;
      exp_q.push_back(16'(i * 4));
      drive(0, 0, 0, 0, 16'h0, 1);
      see("t1", 1, 16'(i * 4), 0, 0);
    end
    // T3: jump while request at 0x0010 outstanding
    tick; drive(0, 0, 0, 0, 16'h0, 0);      see("t3_raise", 1, 16'h0010, 0, 0);
    tick; drive(0, 0, 0, 1, 16'h0100, 0);   see("t3_jump", 1, 16'h0010, 1, 0);
    tick; drive(0, 0, 0, 0, 16'h0, 1);      see("t3_drain_ack", 1, 16'h0010, 0, 0);
    // T2: stall before and after request raised
    tick; drive(1, 0, 0, 0, 16'h0, 0);      see("t2_stall", 0, 0, 0, 0);
    tick; drive(0, 0, 0, 0, 16'h0, 0);      see("t2_raise", 1, 16'h0100, 0, 0);
    tick; drive(1, 0, 0, 0, 16'h0, 0);      see("t2_hold1", 1, 16'h0100, 0, 0);
    tick; drive(1, 0, 0, 0, 16'h0, 0);      see("t2_hold2", 1, 16'h0100, 0, 0);
    tick; exp_q.push_back(16'h0100);
    drive(1, 0, 0, 0, 16'h0, 1);            see("t2_ack", 1, 16'h0100, 0, 0);
    // T4: newest redirect in DRAIN wins
    tick; drive(0, 0, 0, 0, 16'h0, 0);      see("t4_raise", 1, 16'h0104, 0, 0);
    tick; drive(0, 0, 0, 1, 16'h0300, 0);   see("t4_jump", 1, 16'h0104, 1, 0);
    tick; drive(0, 1, 1, 0, 16'h0200, 0);   see("t4_branch", 1, 16'h0104, 1, 0);
    tick; drive(0, 0, 0, 0, 16'h0, 1);      see("t4_ack", 1, 16'h0104, 0, 0);
    tick; exp_q.push_back(16'h0200);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t4_target", 1, 16'h0200, 0, 0);
    // T5: not-taken branch, misaligned jump
    tick; exp_q.push_back(16'h0204);
    drive(0, 1, 0, 0, 16'h0500, 1);         see("t5_nt", 1, 16'h0204, 0, 0);
    tick; exp_q.push_back(16'h0208);
    drive(0, 0, 0, 1, 16'h0102, 1);         see("t5_mis", 1, 16'h0208, 0, 1);
    tick; exp_q.push_back(16'h020C);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t5_seq", 1, 16'h020C, 0, 0);
    // redirect coinciding with ack drops the word
    tick; drive(0, 0, 0, 1, 16'hFFF8, 1);   see("ackredir", 1, 16'h0210, 1, 0);
    // T6: wrap at top of address space
    tick; exp_q.push_back(16'hFFF8);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t6_fff8", 1, 16'hFFF8, 0, 0);
    tick; exp_q.push_back(16'hFFFC);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t6_fffc", 1, 16'hFFFC, 0, 0);
    tick; exp_q.push_back(16'h0000);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t6_wrap", 1, 16'h0000, 0, 0);
    // redirect with nothing outstanding retargets immediately
    tick; drive(1, 0, 0, 1, 16'h0040, 0);   see("idle_redir", 0, 0, 1, 0);
    tick; exp_q.push_back(16'h0040);
    drive(0, 0, 0, 0, 16'h0, 1);            see("idle_target", 1, 16'h0040, 0, 0);
    // T6: reset in DRAIN
    tick; drive(0, 0, 0, 0, 16'h0, 0);      see("t6_raise", 1, 16'h0044, 0, 0);
    tick; drive(0, 0, 0, 1, 16'h0080, 0);   see("t6_jump", 1, 16'h0044, 1, 0);
    tick; rst = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 0);            see("t6_drain", 1, 16'h0044, 0, 0);
    tick; rst = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 1);            see("t6_idle", 0, 0, 0, 0);
    chk("t6_idle_valid", {15'd0, instr_valid}, 16'd0);
    tick; exp_q.push_back(16'h0000);
    drive(0, 0, 0, 0, 16'h0, 1);            see("t6_restart", 1, 16'h0000, 0, 0);
    tick; drive(0, 0, 0, 0, 16'h0, 0);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
